// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out bit serializer.
// State encoding and counter width helpers.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // A zero-cycle gap still needs a legal one-bit counter.
    function automatic int gap_width(input int gap_cycles);
        return (gap_cycles > 0) ? $clog2(gap_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Serializes WIDTH-bit words onto a registered bit stream with a strobe,
// optional idle gap per word, and a synchronous flush.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0,
    parameter bit IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = gap_width(GAP_CYCLES);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic [GW-1:0]    gcnt;
    logic             last;
    logic             gap_last;
    logic             accept;
    logic             head_bit;
    logic             first_bit;

    // Shift so the next bit to send always sits at the head position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
        else           return {1'b0, v[WIDTH-1:1]};
    endfunction

    assign last      = (cnt == CW'(WIDTH - 1));
    assign gap_last  = (gcnt == GW'(GAP_CYCLES - 1));
    assign head_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign first_bit = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    assign accept    = data_valid & data_ready;
    assign busy      = (state != IDLE);

    always_comb begin
        data_ready = 1'b0;
        if (!flush) begin
            data_ready = (state == IDLE) ||
                         (state == SHIFT && last && GAP_CYCLES == 0);
        end
    end

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) state_n = SHIFT;
                end
                SHIFT: begin
                    if (last) begin
                        if (accept)              state_n = SHIFT;
                        else if (GAP_CYCLES > 0) state_n = GAP;
                        else                     state_n = IDLE;
                    end
                end
                GAP: begin
                    if (gap_last) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            bit_out   <= IDLE_BIT;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
        end else if (flush) begin
            cnt       <= '0;
            gcnt      <= '0;
            bit_out   <= IDLE_BIT;
            bit_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (accept) begin
                shreg     <= advance(data_in);
                bit_out   <= first_bit;
                bit_valid <= 1'b1;
                cnt       <= '0;
            end else begin
                unique case (state)
                    SHIFT: begin
                        if (!last) begin
                            shreg     <= advance(shreg);
                            bit_out   <= head_bit;
                            cnt       <= cnt + CW'(1);
                            word_done <= (cnt == CW'(WIDTH - 2));
                        end else begin
                            bit_out   <= IDLE_BIT;
                            bit_valid <= 1'b0;
                            cnt       <= '0;
                            gcnt      <= '0;
                        end
                    end
                    GAP: begin
                        if (!gap_last) gcnt <= gcnt + GW'(1);
                    end
                    default: begin
                        bit_out   <= IDLE_BIT;
                        bit_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: three parameterizations share clk/rst,
// a tiny 1010 Moore detector rides on the WIDTH=10 stream.
module tb_bit_serializer;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int chk  = 0;
    int pass = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ea, eb, ec;

    // A: WIDTH=8, MSB first, no gap
    logic       a_flush = 0, a_valid = 0;
    logic [7:0] a_data = 0;
    logic       a_ready, a_bit, a_bv, a_done, a_busy;
    // B: WIDTH=8, LSB first, 3-cycle gap
    logic       b_flush = 0, b_valid = 0;
    logic [7:0] b_data = 0;
    logic       b_ready, b_bit, b_bv, b_done, b_busy;
    // C: WIDTH=10, MSB first, no gap
    logic       c_flush = 0, c_valid = 0;
    logic [9:0] c_data = 0;
    logic       c_ready, c_bit, c_bv, c_done, c_busy;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .data_in(a_data),
        .data_valid(a_valid), .data_ready(a_ready), .bit_out(a_bit),
        .bit_valid(a_bv), .word_done(a_done), .busy(a_busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(3), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .data_in(b_data),
        .data_valid(b_valid), .data_ready(b_ready), .bit_out(b_bit),
        .bit_valid(b_bv), .word_done(b_done), .busy(b_busy)
    );

    bit_serializer #(.WIDTH(10), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) dut_c (
        .clk(clk), .rst(rst), .flush(c_flush), .data_in(c_data),
        .data_valid(c_valid), .data_ready(c_ready), .bit_out(c_bit),
        .bit_valid(c_bv), .word_done(c_done), .busy(c_busy)
    );

    // Detector under test downstream: Moore, flags when the last four valid bits are 1010.
    logic [3:0] hist;
    logic       det;
    always @(posedge clk or posedge rst) begin
        if (rst)       hist <= 4'b0;
        else if (c_bv) hist <= {hist[2:0], c_bit};
    end
    assign det = (hist == 4'b1010);

    always @(negedge clk) begin
        if (!rst) begin
            chk++;
            if (a_bv) begin
                if (qa.size() == 0) begin
                    $display("FAIL a_extra_bit: bit_out=%b with empty scoreboard", a_bit);
                end else begin
                    ea = qa.pop_front();
                    if (a_bit !== ea.b || a_done !== ea.last)
                        $display("FAIL a_stream: got bit=%b done=%b want bit=%b done=%b",
                                 a_bit, a_done, ea.b, ea.last);
                    else pass++;
                end
            end else if (a_bit !== 1'b0 || a_done !== 1'b0) begin
                $display("FAIL a_idle: got bit=%b done=%b want 0 0", a_bit, a_done);
            end else pass++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk++;
            if (b_bv) begin
                if (qb.size() == 0) begin
                    $display("FAIL b_extra_bit: bit_out=%b with empty scoreboard", b_bit);
                end else begin
                    eb = qb.pop_front();
                    if (b_bit !== eb.b || b_done !== eb.last)
                        $display("FAIL b_stream: got bit=%b done=%b want bit=%b done=%b",
                                 b_bit, b_done, eb.b, eb.last);
                    else pass++;
                end
            end else if (b_bit !== 1'b0 || b_done !== 1'b0) begin
                $display("FAIL b_idle: got bit=%b done=%b want 0 0", b_bit, b_done);
            end else pass++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk++;
            if (c_bv) begin
                if (qc.size() == 0) begin
                    $display("FAIL c_extra_bit: bit_out=%b with empty scoreboard", c_bit);
                end else begin
                    ec = qc.pop_front();
                    if (c_bit !== ec.b || c_done !== ec.last)
                        $display("FAIL c_stream: got bit=%b done=%b want bit=%b done=%b",
                                 c_bit, c_done, ec.b, ec.last);
                    else pass++;
                end
            end else if (c_bit !== 1'b0 || c_done !== 1'b0) begin
                $display("FAIL c_idle: got bit=%b done=%b want 0 0", c_bit, c_done);
            end else pass++;
        end
    end

    task automatic push_word(input int which, input logic [15:0] w,
                             input int width, input bit msb);
        exp_t e;
        int idx;
        for (int k = 0; k < width; k++) begin
            idx    = msb ? (width - 1 - k) : k;
            e.b    = w[idx];
            e.last = (k == width - 1);
            if (which == 0)      qa.push_back(e);
            else if (which == 1) qb.push_back(e);
            else                 qc.push_back(e);
        end
    endtask

    task automatic test_reset();
        #1;
        chk++;
        if (a_bv !== 0 || a_bit !== 0 || a_done !== 0 || a_busy !== 0 || a_ready !== 1)
            $display("FAIL reset_a: got bv=%b bit=%b done=%b busy=%b ready=%b want 0 0 0 0 1",
                     a_bv, a_bit, a_done, a_busy, a_ready);
        else pass++;
        chk++;
        if (b_bv !== 0 || b_busy !== 0 || c_bv !== 0 || c_busy !== 0)
            $display("FAIL reset_bc: got b_bv=%b b_busy=%b c_bv=%b c_busy=%b want 0",
                     b_bv, b_busy, c_bv, c_busy);
        else pass++;
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        a_data  = 8'hF0;
        a_valid = 1;
        push_word(0, 16'(8'hF0), 8, 1'b1);
        @(negedge clk);
        a_valid = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        #1;
        chk++;
        if (a_bv !== 0 || a_bit !== 0 || a_busy !== 0 || a_done !== 0)
            $display("FAIL reset_mid_word: got bv=%b bit=%b busy=%b done=%b want 0 0 0 0",
                     a_bv, a_bit, a_busy, a_done);
        else pass++;
        @(negedge clk);
        qa.delete();
        rst = 0;
        @(negedge clk);
        chk++;
        if (a_bv !== 0 || a_busy !== 0)
            $display("FAIL reset_no_resume: got bv=%b busy=%b want 0 0", a_bv, a_busy);
        else pass++;
    endtask

    task automatic test_single_word();
        @(negedge clk);
        a_data  = 8'hB4;
        a_valid = 1;
        chk++;
        if (a_ready !== 1) $display("FAIL single_ready_idle: got %b want 1", a_ready);
        else pass++;
        push_word(0, 16'(8'hB4), 8, 1'b1);
        @(negedge clk);
        a_valid = 0;
        a_data  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            chk++;
            if (a_bv !== 1 || a_ready !== (i == 7))
                $display("FAIL single_bit%0d: got bv=%b ready=%b want 1 %b",
                         i, a_bv, a_ready, (i == 7));
            else pass++;
        end
        @(negedge clk);
        chk++;
        if (a_bv !== 0 || a_busy !== 0 || qa.size() != 0)
            $display("FAIL single_end: got bv=%b busy=%b left=%0d want 0 0 0",
                     a_bv, a_busy, qa.size());
        else pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a_data  = 8'hCA;
        a_valid = 1;
        chk++;
        if (a_ready !== 1) $display("FAIL b2b_ready_idle: got %b want 1", a_ready);
        else pass++;
        push_word(0, 16'(8'hCA), 8, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk++;
            if (a_bv !== 1 || a_ready !== (i == 7 || i == 15))
                $display("FAIL b2b_cycle%0d: got bv=%b ready=%b want 1 %b",
                         i, a_bv, a_ready, (i == 7 || i == 15));
            else pass++;
            if (i == 7) begin
                a_data = 8'h55;
                push_word(0, 16'(8'h55), 8, 1'b1);
            end
            if (i == 15) a_valid = 0;
        end
        @(negedge clk);
        chk++;
        if (a_bv !== 0 || a_busy !== 0 || qa.size() != 0)
            $display("FAIL b2b_end: got bv=%b busy=%b left=%0d want 0 0 0",
                     a_bv, a_busy, qa.size());
        else pass++;
    endtask

    task automatic test_flush();
        @(negedge clk);
        a_data  = 8'hFF;
        a_valid = 1;
        push_word(0, 16'(8'hFF), 8, 1'b1);
        @(negedge clk);
        a_valid = 0;
        repeat (3) @(negedge clk);
        a_flush = 1;
        @(negedge clk);
        a_flush = 0;
        chk++;
        if (a_bv !== 0 || a_done !== 0 || a_busy !== 0)
            $display("FAIL flush_abort: got bv=%b done=%b busy=%b want 0 0 0",
                     a_bv, a_done, a_busy);
        else pass++;
        qa.delete();
        a_flush = 1;
        a_data  = 8'h0F;
        a_valid = 1;
        #1;
        chk++;
        if (a_ready !== 0) $display("FAIL flush_ready: got %b want 0", a_ready);
        else pass++;
        @(negedge clk);
        chk++;
        if (a_bv !== 0 || a_busy !== 0)
            $display("FAIL flush_priority: got bv=%b busy=%b want 0 0", a_bv, a_busy);
        else pass++;
        a_flush = 0;
        push_word(0, 16'(8'h0F), 8, 1'b1);
        @(negedge clk);
        a_valid = 0;
        repeat (8) @(negedge clk);
        chk++;
        if (a_busy !== 0 || qa.size() != 0)
            $display("FAIL flush_next_word: got busy=%b left=%0d want 0 0", a_busy, qa.size());
        else pass++;
    endtask

    task automatic test_gap_lsb();
        int n;
        int gap;
        @(negedge clk);
        b_data  = 8'h01;
        b_valid = 1;
        chk++;
        if (b_ready !== 1) $display("FAIL gap_ready_idle: got %b want 1", b_ready);
        else pass++;
        push_word(1, 16'(8'h01), 8, 1'b0);
        @(negedge clk);
        b_data = 8'h80;
        n   = 1;
        gap = 0;
        while (!b_ready && n < 40) begin
            if (b_busy && !b_bv) gap++;
            @(negedge clk);
            n++;
        end
        chk++;
        if (n != 12 || gap != 3)
            $display("FAIL gap_first: got ready_after=%0d gap=%0d want 12 3", n, gap);
        else pass++;
        push_word(1, 16'(8'h80), 8, 1'b0);
        @(negedge clk);
        b_valid = 0;
        n   = 1;
        gap = 0;
        while (b_busy && n < 40) begin
            if (!b_bv) gap++;
            @(negedge clk);
            n++;
        end
        chk++;
        if (n != 12 || gap != 3 || qb.size() != 0)
            $display("FAIL gap_second: got idle_after=%0d gap=%0d left=%0d want 12 3 0",
                     n, gap, qb.size());
        else pass++;
    endtask

    task automatic test_detector_chain();
        logic [9:0] w;
        logic [3:0] g;
        int hits;
        w    = 10'b1100101010;
        g    = 4'b0;
        hits = 0;
        @(negedge clk);
        c_data  = w;
        c_valid = 1;
        push_word(2, 16'(w), 10, 1'b1);
        @(negedge clk);
        c_valid = 0;
        for (int i = 0; i <= 10; i++) begin
            if (i > 0) @(negedge clk);
            chk++;
            if (det !== (g == 4'b1010))
                $display("FAIL det_cycle%0d: got %b want %b", i, det, (g == 4'b1010));
            else pass++;
            if (det === 1'b1) hits++;
            if (i < 10) g = {g[2:0], w[9-i]};
        end
        chk++;
        if (hits != 2 || qc.size() != 0)
            $display("FAIL det_hits: got hits=%0d left=%0d want 2 0", hits, qc.size());
        else pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_flush();
        test_gap_lsb();
        test_detector_chain();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
